// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
// Holds the FSM state encoding, the buffered entry layout and the PC step.
package fetch_pkg;

  localparam int FETCH_INSTR_W = 32;
  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are word aligned; the low two bits are simply dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular instruction buffer between icache and decode.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A flush empties the buffer and takes priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [PW:0]   r_count;

  logic w_pop;
  logic w_push;

  assign full  = (r_count == CNT_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rdPtr];

  // A pop on an empty buffer is meaningless; a push into a full one needs a pop.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge CLK) begin
    if (w_push && !flush) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN || flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and instruction buffering ahead of decode.
// Drives the icache address from the pc register, buffers returned
// instructions with their PCs, and restarts fetch on execute redirects.
// Optional macro FETCH_BYPASS_EN forwards an icache return straight to
// decode when the buffer is empty, saving one cycle of latency.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          INSTR_SIZE   = 32,
  parameter int          DEPTH        = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  output logic [31:0]           IP,
  input  logic [INSTR_SIZE-1:0] IC_INSTR,
  input  logic                  IC_VALID,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  output logic                  DEC_VALID,
  input  logic                  DEC_READY,
  output logic [INSTR_SIZE-1:0] DEC_INSTR,
  output logic [31:0]           DEC_PC,
  output logic                  ERR_MISALIGN
);

  // Width-parameterised form of fetch_entry_t so INSTR_SIZE can follow the icache.
  typedef struct packed {
    logic [31:0]           pc;
    logic [INSTR_SIZE-1:0] instr;
  } entry_t;

  localparam int PW = $clog2(DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_nextState;
  logic [31:0]  r_pc;
  logic         r_errMisalign;

  entry_t       w_wdata;
  entry_t       w_rdata;
  logic [PW:0]  w_count;
  logic         w_full;
  logic         w_empty;

  logic         w_headValid;
  logic         w_icFire;
  logic         w_accept;
  logic         w_fifoPush;
  logic         w_fifoPop;
  logic         w_bypass;

  assign IP           = r_pc;
  assign ERR_MISALIGN = r_errMisalign;

  // An icache return is only usable in FETCH and never alongside a redirect.
  assign w_icFire    = (r_state == FETCH) && IC_VALID && !REDIRECT;
  assign w_headValid = (w_count != '0);
  assign w_fifoPop   = w_headValid && DEC_READY;
  assign w_accept    = w_icFire && (!w_full || w_fifoPop);
  assign w_wdata     = '{pc: r_pc, instr: IC_INSTR};

`ifdef FETCH_BYPASS_EN
  assign w_bypass   = w_empty && w_icFire;
  assign w_fifoPush = w_accept && !(w_bypass && DEC_READY);
  assign DEC_VALID  = w_headValid || w_bypass;
  assign DEC_INSTR  = w_bypass ? IC_INSTR : (w_empty ? '0 : w_rdata.instr);
  assign DEC_PC     = w_bypass ? r_pc     : (w_empty ? '0 : w_rdata.pc);
`else
  assign w_bypass   = 1'b0;
  assign w_fifoPush = w_accept && !w_bypass;
  assign DEC_VALID  = w_headValid;
  assign DEC_INSTR  = w_empty ? '0 : w_rdata.instr;
  assign DEC_PC     = w_empty ? '0 : w_rdata.pc;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (w_fifoPush),
    .pop   (w_fifoPop),
    .flush (REDIRECT),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a redirect always (re)enters FLUSH with the newest target.
  always_comb begin
    w_nextState = r_state;
    if (REDIRECT) begin
      w_nextState = FLUSH;
    end else begin
      case (r_state)
        BOOT:    w_nextState = FETCH;
        FLUSH:   w_nextState = FETCH;
        FETCH:   w_nextState = FETCH;
        default: w_nextState = BOOT;
      endcase
    end
  end

  // Fetch PC: redirect wins, otherwise advance by one word per accepted return.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_pc <= RESET_VECTOR;
    end else if (REDIRECT) begin
      r_pc <= alignPc(REDIRECT_PC);
    end else if (w_accept) begin
      r_pc <= r_pc + FETCH_STEP;
    end
  end

  // Misalignment flag pulses for one cycle after an unaligned redirect target.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_errMisalign <= 1'b0;
    end else begin
      r_errMisalign <= REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A queue-based reference model tracks what decode should see; directed
// phases cover boot, stall, redirect, misalignment and pc wrap, followed by
// a randomized run with occasional resets and redirects.
module tb_fetch_unit;

  localparam logic [31:0] RV      = 32'h0000_0100;
  localparam int          DEPTH_C = 4;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] IP;
  logic [31:0] IC_INSTR;
  logic        IC_VALID;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        DEC_VALID;
  logic        DEC_READY;
  logic [31:0] DEC_INSTR;
  logic [31:0] DEC_PC;
  logic        ERR_MISALIGN;

  int checks = 0;
  int errors = 0;

  logic [63:0] mQ[$];
  logic [31:0] mPc;
  bit          mBlocked;
  bit          mErr;
  bit          mKnown = 1'b0;

  fetch_unit #(
    .RESET_VECTOR (RV),
    .INSTR_SIZE   (32),
    .DEPTH        (DEPTH_C)
  ) u_dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .IP           (IP),
    .IC_INSTR     (IC_INSTR),
    .IC_VALID     (IC_VALID),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .DEC_VALID    (DEC_VALID),
    .DEC_READY    (DEC_READY),
    .DEC_INSTR    (DEC_INSTR),
    .DEC_PC       (DEC_PC),
    .ERR_MISALIGN (ERR_MISALIGN)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle, derived from the model state.
  task automatic checkCycle();
    bit          eValid;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    eValid = 1'b0;
    ePc    = '0;
    eInstr = '0;
    if (mQ.size() != 0) begin
      eValid = 1'b1;
      {ePc, eInstr} = mQ[0];
    end
`ifdef FETCH_BYPASS_EN
    if (mQ.size() == 0 && !mBlocked && IC_VALID && !REDIRECT) begin
      eValid = 1'b1;
      ePc    = mPc;
      eInstr = IC_INSTR;
    end
`endif
    checkOutput("IP", IP, mPc);
    checkOutput("DEC_VALID", {31'b0, DEC_VALID}, {31'b0, eValid});
    checkOutput("DEC_PC", DEC_PC, ePc);
    checkOutput("DEC_INSTR", DEC_INSTR, eInstr);
    checkOutput("ERR_MISALIGN", {31'b0, ERR_MISALIGN}, {31'b0, mErr});
  endtask

  // Reference model: advance one clock using the inputs just sampled.
  task automatic modelUpdate();
    bit popped;
    bit accepted;
    bit bypassed;
    if (!RSTN) begin
      mQ.delete();
      mPc      = RV;
      mBlocked = 1'b1;
      mErr     = 1'b0;
      mKnown   = 1'b1;
    end else if (REDIRECT) begin
      mQ.delete();
      mPc      = REDIRECT_PC & 32'hFFFF_FFFC;
      mBlocked = 1'b1;
      mErr     = (REDIRECT_PC[1:0] != 2'b00);
    end else begin
      mErr     = 1'b0;
      popped   = (mQ.size() != 0) && DEC_READY;
      accepted = !mBlocked && IC_VALID && ((mQ.size() < DEPTH_C) || popped);
      bypassed = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypassed = accepted && (mQ.size() == 0) && DEC_READY;
`endif
      if (popped) begin
        void'(mQ.pop_front());
      end
      if (accepted) begin
        if (!bypassed) begin
          mQ.push_back({mPc, IC_INSTR});
        end
        mPc = mPc + 32'd4;
      end
      mBlocked = 1'b0;
    end
  endtask

  // One clock: drive on the falling edge, check mid-cycle, update model on the rising edge.
  task automatic applyStimulus(input logic rstn, input logic icv, input logic [31:0] instr,
                               input logic redir, input logic [31:0] rpc, input logic ready);
    @(negedge CLK);
    RSTN        = rstn;
    IC_VALID    = icv;
    IC_INSTR    = instr;
    REDIRECT    = redir;
    REDIRECT_PC = rpc;
    DEC_READY   = ready;
    #1;
    if (mKnown) begin
      checkCycle();
    end
    @(posedge CLK);
    modelUpdate();
  endtask

  initial begin
    RSTN        = 1'b0;
    IC_VALID    = 1'b0;
    IC_INSTR    = '0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    DEC_READY   = 1'b0;

    // Boot with the icache always returning 0x13 and decode always ready.
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h13, 1'b0, '0, 1'b1);
    #1;
    checkOutput("reset IP", IP, 32'h100);
    checkOutput("reset DEC_VALID", {31'b0, DEC_VALID}, 32'd0);
    checkOutput("reset ERR", {31'b0, ERR_MISALIGN}, 32'd0);
    repeat (6) applyStimulus(1'b1, 1'b1, 32'h13, 1'b0, '0, 1'b1);

    // Decode stalls: buffer fills to four entries and the pc holds at 0x110.
    repeat (2) applyStimulus(1'b0, 1'b1, 32'h13, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h1000 + i, 1'b0, '0, 1'b0);
    end
    #1;
    checkOutput("stall IP", IP, 32'h110);
    checkOutput("stall DEC_PC", DEC_PC, 32'h100);
    checkOutput("stall DEC_VALID", {31'b0, DEC_VALID}, 32'd1);

    // Full buffer with simultaneous pop and icache return, then drain.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h2000 + i, 1'b0, '0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

    // Redirect to 0x2000 with three entries buffered.
    applyStimulus(1'b1, 1'b1, 32'hAAAA, 1'b1, 32'h2000, 1'b0);
    #1;
    checkOutput("redirect IP", IP, 32'h2000);
    checkOutput("redirect DEC_VALID", {31'b0, DEC_VALID}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h3000 + i, 1'b0, '0, 1'b1);
    end

    // Misaligned redirect target: aligned fetch plus one-cycle error pulse.
    applyStimulus(1'b1, 1'b1, 32'h4000, 1'b1, 32'h2002, 1'b1);
    #1;
    checkOutput("misalign IP", IP, 32'h2000);
    checkOutput("misalign ERR", {31'b0, ERR_MISALIGN}, 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b1, 32'h4001, 1'b0, '0, 1'b1);

    // Back-to-back redirects, the newest target wins.
    applyStimulus(1'b1, 1'b1, 32'h5000, 1'b1, 32'h7000, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h5001, 1'b1, 32'hFFFF_FFF8, 1'b1);

    // Free-running across the 32-bit pc wrap.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h6000 + i, 1'b0, '0, 1'b1);
    end

    // Randomized traffic with occasional redirects and mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 149) != 0),
                    ($urandom_range(0, 3) != 0),
                    $urandom,
                    ($urandom_range(0, 39) == 0),
                    $urandom,
                    ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
